// File: rtl/genaxis_pkg.sv
// Shared types and widths for the AXI-Stream packet scheduler.
package genaxis_pkg;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned PAUSE_W = 32;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

endpackage

// File: rtl/genaxis_range_clamp.sv
// Clamps a value into [min, max]; the lower bound is applied last so min wins when min > max.
module genaxis_range_clamp #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] in,
    input  logic [W-1:0] min,
    input  logic [W-1:0] max,
    output logic [W-1:0] out
);

    logic [W-1:0] w_upper;

    assign w_upper = (in > max) ? max : in;
    assign out     = (w_upper < min) ? min : w_upper;

endmodule

// File: rtl/genaxis_pkt_scheduler.sv
// Packet scheduler: turns random length/channel/pause/data into AXI-Stream packets
// separated by clamped pauses.
module genaxis_pkt_scheduler
    import genaxis_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic [LEN_W-1:0]      cntrl_min_length_i,
    input  logic [LEN_W-1:0]      cntrl_max_length_i,
    input  logic [ID_WIDTH-1:0]   cntrl_min_channel_i,
    input  logic [ID_WIDTH-1:0]   cntrl_max_channel_i,
    input  logic [PAUSE_W-1:0]    cntrl_min_pause_i,
    input  logic [LEN_W-1:0]      pkt_length_i,
    input  logic [ID_WIDTH-1:0]   pkt_channel_i,
    input  logic [PAUSE_W-1:0]    pkt_pause_i,
    input  logic [DATA_WIDTH-1:0] pkt_data_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [ID_WIDTH-1:0]   m_axis_tid_o,
    output logic                  m_axis_tlast_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      pkt_count_o
);

    logic [LEN_W-1:0]      w_len_clamp;
    logic [LEN_W-1:0]      w_len;
    logic [ID_WIDTH-1:0]   w_chan;
    logic [PAUSE_W-1:0]    w_pause;

    state_t                r_state;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_beat;
    logic [PAUSE_W-1:0]    r_pause;
    logic [PAUSE_W-1:0]    r_pause_cnt;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [ID_WIDTH-1:0]   r_tid;
    logic                  r_tlast;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_pkt_count;

    genaxis_range_clamp #(.W(LEN_W)) u_len_clamp (
        .in  (pkt_length_i),
        .min (cntrl_min_length_i),
        .max (cntrl_max_length_i),
        .out (w_len_clamp)
    );

    genaxis_range_clamp #(.W(ID_WIDTH)) u_chan_clamp (
        .in  (pkt_channel_i),
        .min (cntrl_min_channel_i),
        .max (cntrl_max_channel_i),
        .out (w_chan)
    );

    // Pause has no upper bound, so the max input is pinned to all-ones.
    genaxis_range_clamp #(.W(PAUSE_W)) u_pause_clamp (
        .in  (pkt_pause_i),
        .min (cntrl_min_pause_i),
        .max ('1),
        .out (w_pause)
    );

    assign w_len = (w_len_clamp == '0) ? LEN_W'(1) : w_len_clamp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_beat      <= '0;
            r_pause     <= '0;
            r_pause_cnt <= '0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tid       <= '0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable_i) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_len    <= w_len;
                    r_tid    <= w_chan;
                    r_pause  <= w_pause;
                    r_tdata  <= pkt_data_i;
                    r_beat   <= '0;
                    r_tlast  <= (w_len == LEN_W'(1));
                    r_tvalid <= 1'b1;
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (r_tvalid && m_axis_tready_i) begin
                        r_tdata <= pkt_data_i;
                        if (r_tlast) begin
                            r_tvalid    <= 1'b0;
                            r_tlast     <= 1'b0;
                            r_beat      <= '0;
                            r_pause_cnt <= '0;
                            r_pkt_count <= r_pkt_count + CNT_W'(1);
                            if (r_pause != '0) begin
                                r_state <= ST_PAUSE;
                            end else if (enable_i) begin
                                r_state <= ST_LOAD;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            // Look ahead: the next beat is last when beat+1 == len-1.
                            r_beat  <= r_beat + LEN_W'(1);
                            r_tlast <= ((r_beat + LEN_W'(2)) == r_len);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (r_pause_cnt == (r_pause - PAUSE_W'(1))) begin
                        r_pause_cnt <= '0;
                        if (enable_i) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_pause_cnt <= r_pause_cnt + PAUSE_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tdata_o  = r_tdata;
    assign m_axis_tid_o    = r_tid;
    assign m_axis_tlast_o  = r_tlast;
    assign busy_o          = r_busy;
    assign pkt_count_o     = r_pkt_count;

endmodule

// File: tb/tb_genaxis_pkt_scheduler.sv
// Scoreboard bench for genaxis_pkt_scheduler: expected packets are queued per phase,
// a negedge monitor checks beats, gaps, pause tails and packet counts.
module tb_genaxis_pkt_scheduler;

    localparam int unsigned IDW = 10;
    localparam int unsigned DW  = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            enable_i = 1'b0;
    logic [15:0]     cntrl_min_length_i = '0;
    logic [15:0]     cntrl_max_length_i = '0;
    logic [IDW-1:0]  cntrl_min_channel_i = '0;
    logic [IDW-1:0]  cntrl_max_channel_i = '0;
    logic [31:0]     cntrl_min_pause_i = '0;
    logic [15:0]     pkt_length_i = '0;
    logic [IDW-1:0]  pkt_channel_i = '0;
    logic [31:0]     pkt_pause_i = '0;
    logic [DW-1:0]   pkt_data_i = '0;
    logic            m_axis_tvalid_o;
    logic            m_axis_tready_i = 1'b1;
    logic [DW-1:0]   m_axis_tdata_o;
    logic [IDW-1:0]  m_axis_tid_o;
    logic            m_axis_tlast_o;
    logic            busy_o;
    logic [31:0]     pkt_count_o;

    genaxis_pkt_scheduler #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .enable_i            (enable_i),
        .cntrl_min_length_i  (cntrl_min_length_i),
        .cntrl_max_length_i  (cntrl_max_length_i),
        .cntrl_min_channel_i (cntrl_min_channel_i),
        .cntrl_max_channel_i (cntrl_max_channel_i),
        .cntrl_min_pause_i   (cntrl_min_pause_i),
        .pkt_length_i        (pkt_length_i),
        .pkt_channel_i       (pkt_channel_i),
        .pkt_pause_i         (pkt_pause_i),
        .pkt_data_i          (pkt_data_i),
        .m_axis_tvalid_o     (m_axis_tvalid_o),
        .m_axis_tready_i     (m_axis_tready_i),
        .m_axis_tdata_o      (m_axis_tdata_o),
        .m_axis_tid_o        (m_axis_tid_o),
        .m_axis_tlast_o      (m_axis_tlast_o),
        .busy_o              (busy_o),
        .pkt_count_o         (pkt_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned l;
        int unsigned c;
        int unsigned p;
        bit          is_first;
        bit          is_last;
    } exp_t;

    exp_t        sbq[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned started = 0;
    int unsigned done_cnt = 0;
    int unsigned exp_total = 0;
    int unsigned tr_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned clampv(int unsigned v, int unsigned lo, int unsigned hi);
        int unsigned r = v;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // Fresh payload word every cycle.
    initial forever begin
        @(posedge clk); #1;
        pkt_data_i = $urandom;
    end

    // Backpressure: always ready, random, or the repeating 1,0,0,1 pattern.
    initial begin
        bit pat[4];
        int unsigned idx = 0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tr_mode)
                0:       m_axis_tready_i = 1'b1;
                1:       m_axis_tready_i = 1'($urandom_range(0, 1));
                default: begin
                    m_axis_tready_i = pat[idx];
                    idx = (idx + 1) % 4;
                end
            endcase
        end
    end

    // Monitor state
    exp_t          cur;
    bit            in_pkt = 0, stall = 0, tail = 0;
    int unsigned   beat = 0, gap = 0, last_p = 0, tail_cnt = 0;
    logic [DW-1:0] prev_data = '0, exp_data = '0, h_data = '0;
    logic [IDW-1:0] h_tid = '0;
    logic          h_tlast = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_pkt = 0; stall = 0; tail = 0; done_cnt = 0; gap = 0; beat = 0;
        end else if (m_axis_tvalid_o) begin
            if (!in_pkt) begin
                chk("pkt_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    cur = sbq.pop_front();
                    in_pkt = 1; beat = 0; stall = 0; started++;
                    chk("first_data", m_axis_tdata_o, prev_data);
                    chk("busy_in_pkt", busy_o, 1);
                    if (!cur.is_first) chk("gap_cycles", gap, last_p + 1);
                end
            end else if (stall) begin
                chk("stall_tdata", m_axis_tdata_o, h_data);
                chk("stall_tid", m_axis_tid_o, h_tid);
                chk("stall_tlast", m_axis_tlast_o, h_tlast);
            end else begin
                chk("beat_data", m_axis_tdata_o, exp_data);
            end
            if (in_pkt) begin
                chk("tid", m_axis_tid_o, cur.c);
                chk("tlast", m_axis_tlast_o, 64'(beat == cur.l - 1));
                if (m_axis_tready_i) begin
                    stall = 0;
                    exp_data = pkt_data_i;
                    if (m_axis_tlast_o) begin
                        chk("pkt_count", pkt_count_o, done_cnt);
                        done_cnt++;
                        in_pkt = 0; gap = 0; last_p = cur.p;
                        if (cur.is_last) begin
                            tail = 1; tail_cnt = 0;
                        end
                    end else begin
                        beat++;
                    end
                end else begin
                    stall = 1;
                    h_data = m_axis_tdata_o; h_tid = m_axis_tid_o; h_tlast = m_axis_tlast_o;
                end
            end
        end else begin
            chk("valid_continuous", 64'(in_pkt), 64'd0);
            in_pkt = 0;
            gap++;
            if (tail) begin
                if (busy_o) tail_cnt++;
                else begin
                    chk("pause_tail", tail_cnt, last_p);
                    tail = 0;
                end
            end
        end
        prev_data = pkt_data_i;
    end

    task automatic wait_started(input int unsigned target);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (started >= target) break;
        end
        chk("start_timeout", 64'(started >= target), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (!busy_o) break;
        end
        chk("idle_timeout", busy_o, 0);
    endtask

    task automatic load_cfg(input int unsigned len, input int unsigned lmin, input int unsigned lmax,
                            input int unsigned ch, input int unsigned cmin, input int unsigned cmax,
                            input int unsigned p, input int unsigned pmin, input int unsigned npkts);
        exp_t e;
        pkt_length_i = 16'(len); cntrl_min_length_i = 16'(lmin); cntrl_max_length_i = 16'(lmax);
        pkt_channel_i = IDW'(ch); cntrl_min_channel_i = IDW'(cmin); cntrl_max_channel_i = IDW'(cmax);
        pkt_pause_i = p; cntrl_min_pause_i = pmin;
        e.l = clampv(len, lmin, lmax);
        if (e.l == 0) e.l = 1;
        e.c = clampv(ch, cmin, cmax);
        e.p = (p > pmin) ? p : pmin;
        for (int i = 0; i < int'(npkts); i++) begin
            e.is_first = (i == 0);
            e.is_last  = (i == int'(npkts) - 1);
            sbq.push_back(e);
        end
        exp_total += npkts;
    endtask

    task automatic run_phase(input int unsigned len, input int unsigned lmin, input int unsigned lmax,
                             input int unsigned ch, input int unsigned cmin, input int unsigned cmax,
                             input int unsigned p, input int unsigned pmin, input int unsigned npkts,
                             input int unsigned mode, input int unsigned drop_delay);
        int unsigned target;
        @(negedge clk); #1;
        tr_mode = mode;
        target = started + npkts;
        load_cfg(len, lmin, lmax, ch, cmin, cmax, p, pmin, npkts);
        enable_i = 1'b1;
        wait_started(target);
        repeat (drop_delay) @(negedge clk);
        #1;
        enable_i = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("pkt_count_end", pkt_count_o, exp_total);
        chk("pkts_done", done_cnt, exp_total);
        chk("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_tvalid", m_axis_tvalid_o, 0);
        chk("rst_tlast", m_axis_tlast_o, 0);
        chk("rst_tdata", m_axis_tdata_o, 0);
        chk("rst_tid", m_axis_tid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", pkt_count_o, 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_enable", busy_o, 0);

        run_phase(4, 4, 4, 5, 0, 1023, 0, 0, 3, 0, 0);
        run_phase(16'h0100, 2, 8, 700, 0, 500, 0, 0, 2, 1, 0);
        run_phase(0, 0, 10, 3, 5, 9, 1, 0, 3, 0, 0);
        run_phase(10, 0, 10, 9, 0, 1023, 3, 5, 3, 2, 0);
        run_phase(6, 0, 16, 77, 0, 1023, 2, 0, 1, 0, 1);
        run_phase(2, 7, 3, 1, 20, 5, 0, 0, 2, 1, 0);
        for (int k = 0; k < 8; k++) begin
            run_phase($urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 10),
                      $urandom_range(0, 1023), $urandom_range(0, 300), $urandom_range(0, 1023),
                      $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(1, 3),
                      $urandom_range(0, 2), 0);
        end

        // Reset in the middle of a 6-beat packet.
        @(negedge clk); #1;
        tr_mode = 0;
        load_cfg(6, 0, 16, 300, 0, 1023, 0, 0, 1);
        enable_i = 1'b1;
        wait_started(started + 1);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_tvalid", m_axis_tvalid_o, 0);
        chk("midrst_tlast", m_axis_tlast_o, 0);
        chk("midrst_tdata", m_axis_tdata_o, 0);
        chk("midrst_tid", m_axis_tid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_count", pkt_count_o, 0);
        sbq.delete();
        exp_total = 0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        run_phase(5, 0, 16, 42, 0, 1023, 1, 0, 2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/genaxis_pkt_scheduler.md
GENAXIS_PKT_SCHEDULER -- requirements
Module: genaxis_pkt_scheduler

Interface
REQ-001 Parameter ID_WIDTH, default 10, width of the channel/TID field.
REQ-002 Parameter DATA_WIDTH, default 32, width of the TDATA field.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable_i  input  1  level; 1 = keep generating packets.
REQ-006 cntrl_min_length_i / cntrl_max_length_i  input  16 each  packet length bounds in beats.
REQ-007 cntrl_min_channel_i / cntrl_max_channel_i  input  ID_WIDTH each  channel bounds.
REQ-008 cntrl_min_pause_i  input  32  minimum inter-packet gap in cycles.
REQ-009 pkt_length_i  input  16  random length from the generator.
REQ-010 pkt_channel_i  input  ID_WIDTH  random channel from the generator.
REQ-011 pkt_pause_i  input  32  random pause from the generator.
REQ-012 pkt_data_i  input  DATA_WIDTH  random payload word, new value every cycle.
REQ-013 m_axis_tvalid_o  output  1; m_axis_tready_i  input  1; m_axis_tdata_o  output  DATA_WIDTH; m_axis_tid_o  output  ID_WIDTH; m_axis_tlast_o  output  1.
REQ-014 busy_o  output  1  1 whenever the state is not IDLE.
REQ-015 pkt_count_o  output  32  count of completed packets (TLAST handshakes).

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SEND and PAUSE.
REQ-017 IDLE -> LOAD SHALL occur when enable_i=1.
REQ-018 LOAD SHALL last one cycle, capture the clamped length, channel, pause and first data word, then go to SEND.
REQ-019 Length clamp: L = max(min(pkt_length_i, cntrl_max_length_i), cntrl_min_length_i); L=0 is forced to 1; result is beats per packet.
REQ-020 Channel clamp: C = max(min(pkt_channel_i, cntrl_max_channel_i), cntrl_min_channel_i).
REQ-021 Pause clamp: P = max(pkt_pause_i, cntrl_min_pause_i); no upper clamp.
REQ-022 If min > max for any field, the min value SHALL win.
REQ-023 In SEND, tvalid=1, tid=C for the whole packet, and a 16-bit beat counter starts at 0.
REQ-024 tdata, tid and tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-025 On each handshake (tvalid & tready), tdata SHALL load pkt_data_i and the beat counter SHALL increment.
REQ-026 tlast SHALL be 1 exactly when beat counter = L-1.
REQ-027 On the TLAST handshake, pkt_count_o SHALL increment (wrapping at 2^32-1 -> 0), then: P>0 -> PAUSE; P=0 and enable_i=1 -> LOAD; else -> IDLE.
REQ-028 PAUSE SHALL hold tvalid=0 for exactly P cycles, then go to LOAD if enable_i=1, else IDLE.
REQ-029 Deassertion of enable_i during SEND or PAUSE SHALL NOT truncate a packet or pause; it is sampled only at the exit points in REQ-027/028.
REQ-030 Control inputs SHALL be sampled only in LOAD; changes mid-packet have no effect on the current packet.
REQ-031 Minimum gap between packets: one cycle (LOAD) when P=0.

Reset
REQ-032 On reset_n=0 the block SHALL go immediately to IDLE, with tvalid=0, tlast=0, tdata=0, tid=0, busy_o=0, pkt_count_o=0 and all counters 0, including mid-packet.
REQ-033 After reset release, the first LOAD SHALL occur no earlier than the first posedge at which enable_i=1.

Structure
REQ-034 The state enum typedef and the state encoding SHALL be placed in the shared package genaxis_pkg.
REQ-035 A combinational sub-module genaxis_range_clamp (parameter W; in, min, max -> out) SHALL implement REQ-019..022 and be instantiated three times.
REQ-036 All outputs SHALL be driven directly from registers.

Verification
REQ-037 Lengths min=max=4, pause min=0 with pkt_pause_i=0, tready=1, enable held -> packets of 4 beats, tlast on beat 3, one idle cycle between packets.
REQ-038 pkt_length_i=0x0100 with max=8, min=2 -> 8-beat packets; pkt_length_i=0 with min=0 -> 1-beat packet with tlast=1.
REQ-039 tready toggled 1,0,0,1 during SEND -> tdata, tid and tlast are constant across the stalled cycles, and no beats are lost or duplicated.
REQ-040 pkt_pause_i=3 with cntrl_min_pause_i=5 -> exactly 5 tvalid=0 cycles in PAUSE before LOAD.
REQ-041 enable_i dropped at beat 1 of a 6-beat packet -> all 6 beats are sent, the pause completes, then IDLE with busy_o=0.
REQ-042 reset_n asserted at beat 2 -> outputs are 0 asynchronously and pkt_count_o=0; after release with enable_i=1 -> a new packet starts at beat 0.
